// File: rtl/ctrl_seq_decoder.sv
// Sequential control decoder: turns fetched opcodes into registered datapath controls,
// with a multi-cycle load stall, a post-branch squash window, HALT/done and a retire counter.
module ctrl_seq_decoder #(
    parameter int unsigned OPWIDTH   = 3,
    parameter int unsigned MCODEBITS = 3,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 instr_valid,
    output logic                 RegDst,
    output logic                 Branch,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 ctrl_valid,
    output logic                 stall,
    output logic                 done,
    output logic [CNTW-1:0]      instr_count
);

    localparam int unsigned WAITW = 4;
    localparam int unsigned SQW   = 3;
    localparam logic [WAITW-1:0]   LAT     = WAITW'(LOAD_LAT);
    localparam logic [SQW-1:0]     FLUSH   = SQW'(FLUSH_CYC);
    localparam logic [OPWIDTH-1:0] ALU_NOP = '1;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_BRCH  = 3'b010;
    localparam logic [2:0] OP_HALT  = 3'b011;

    typedef enum logic [1:0] {IDLE, RUN, LWAIT, HALT} state_t;

    state_t           state;
    logic [WAITW-1:0] wait_cnt;
    logic [SQW-1:0]   squash_cnt;
    logic [2:0]       opcode;

    assign opcode = instr[MCODEBITS-1 -: 3];
    assign RegDst = 1'b0;

    // Low instruction bits carry no control information
    if (MCODEBITS > 3) begin : g_low_bits
        logic unused_low_bits;
        assign unused_low_bits = ^instr[MCODEBITS-4:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            squash_cnt  <= '0;
            Branch      <= 1'b0;
            MemtoReg    <= 1'b0;
            MemWrite    <= 1'b0;
            ALUSrc      <= 1'b0;
            RegWrite    <= 1'b0;
            ALUOp       <= ALU_NOP;
            ctrl_valid  <= 1'b0;
            stall       <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
        end else begin
            // Every cycle defaults to the NOP control set; done is sticky
            Branch     <= 1'b0;
            MemtoReg   <= 1'b0;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            RegWrite   <= 1'b0;
            ALUOp      <= ALU_NOP;
            ctrl_valid <= 1'b0;
            stall      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        instr_count <= '0;
                    end
                end

                HALT: begin
                    if (start) begin
                        state       <= RUN;
                        done        <= 1'b0;
                        instr_count <= '0;
                    end
                end

                // Load held on the bus; write-back happens on the cycle the wait expires
                LWAIT: begin
                    MemtoReg   <= 1'b1;
                    ALUSrc     <= 1'b1;
                    ctrl_valid <= 1'b1;
                    wait_cnt   <= wait_cnt - WAITW'(1);
                    if (wait_cnt == WAITW'(1)) begin
                        RegWrite <= 1'b1;
                        state    <= RUN;
                    end else begin
                        stall <= 1'b1;
                    end
                end

                RUN: begin
                    if (instr_valid && !stall) begin
                        if (squash_cnt != '0) begin
                            squash_cnt <= squash_cnt - SQW'(1);
                        end else begin
                            instr_count <= instr_count + CNTW'(1);
                            ctrl_valid  <= 1'b1;
                            case (opcode)
                                OP_LOAD: begin
                                    ALUSrc   <= 1'b1;
                                    MemtoReg <= 1'b1;
                                    if (LOAD_LAT == 0) begin
                                        RegWrite <= 1'b1;
                                    end else begin
                                        stall    <= 1'b1;
                                        wait_cnt <= LAT;
                                        state    <= LWAIT;
                                    end
                                end
                                OP_STORE: begin
                                    MemWrite <= 1'b1;
                                    ALUSrc   <= 1'b1;
                                end
                                OP_BRCH: begin
                                    Branch     <= 1'b1;
                                    squash_cnt <= FLUSH;
                                end
                                OP_HALT: begin
                                    done  <= 1'b1;
                                    state <= HALT;
                                end
                                default: begin
                                    RegWrite <= 1'b1;
                                    ALUSrc   <= ~opcode[1];
                                    ALUOp    <= OPWIDTH'(opcode);
                                end
                            endcase
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
